serial_code_converter: RTL

SERIAL_CODE_CONVERTER -- requirements
Module: serial_code_converter

---
 rtl/serial_code_converter_if.sv | 26 ++
 rtl/serial_code_converter.sv | 125 ++++++++++++
 2 files changed

// File: rtl/serial_code_converter_if.sv
// Serial code converter port bundle: serial bit in, qualifier and mode from the
// source; converted bit, completion pulses and digit index back to it.
interface serial_code_converter_if #(
  parameter int DIGITS = 4
);
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  logic             X;
  logic             En;
  logic             Mode;
  logic             Z;
  logic             Digit_done;
  logic             Frame_done;
  logic             Err;
  logic [IDX_W-1:0] Digit_idx;

  modport master (
    output X, En, Mode,
    input  Z, Digit_done, Frame_done, Err, Digit_idx
  );

  modport slave (
    input  X, En, Mode,
    output Z, Digit_done, Frame_done, Err, Digit_idx
  );
endinterface

// File: rtl/serial_code_converter.sv
// Bit-serial Excess-3 <-> BCD converter (LSB first, 4-bit digits, Mealy output).
// Define SCC_ERR_EN to build the input shadow and invalid-code checker behind Err.
module serial_code_converter #(
  parameter int DIGITS = 4
) (
  input logic                   Clk,
  input logic                   Rst,
  serial_code_converter_if.slave bus
);
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

  typedef enum logic [1:0] {BIT0, BIT1, BIT2, BIT3} bit_state_t;

  bit_state_t       state_reg, state_next;
  logic             cb_reg, cb_next;
  logic             mode_reg, mode_next;
  logic [IDX_W-1:0] digit_idx_reg, digit_idx_next;
  logic             digit_done_reg, digit_done_next;
  logic             frame_done_reg, frame_done_next;
  logic             err_reg, err_next;
  logic             z;
  logic             accept;
  logic             mode_eff;
  logic             k;
  logic             cb_in;

`ifdef SCC_ERR_EN
  // Bit 3 is never stored: at completion it is the live X.
  logic [2:0] shadow_reg, shadow_next;
  logic [3:0] digit_val;
`endif

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_reg      <= BIT0;
      cb_reg         <= 1'b0;
      mode_reg       <= 1'b0;
      digit_idx_reg  <= '0;
      digit_done_reg <= 1'b0;
      frame_done_reg <= 1'b0;
      err_reg        <= 1'b0;
`ifdef SCC_ERR_EN
      shadow_reg     <= '0;
`endif
    end else begin
      state_reg      <= state_next;
      cb_reg         <= cb_next;
      mode_reg       <= mode_next;
      digit_idx_reg  <= digit_idx_next;
      digit_done_reg <= digit_done_next;
      frame_done_reg <= frame_done_next;
      err_reg        <= err_next;
`ifdef SCC_ERR_EN
      shadow_reg     <= shadow_next;
`endif
    end
  end

  always_comb begin
    state_next      = state_reg;
    cb_next         = cb_reg;
    mode_next       = mode_reg;
    digit_idx_next  = digit_idx_reg;
    digit_done_next = 1'b0;
    frame_done_next = 1'b0;
    err_next        = 1'b0;
    z               = 1'b0;
    accept          = bus.En && !Rst;
    // Mode is only honoured at bit 0; later bits use the latched copy.
    mode_eff        = (state_reg == BIT0) ? bus.Mode : mode_reg;
    k               = (state_reg == BIT0) || (state_reg == BIT1);
    cb_in           = (state_reg == BIT0) ? 1'b0 : cb_reg;
`ifdef SCC_ERR_EN
    shadow_next     = shadow_reg;
    digit_val       = {bus.X, shadow_reg};
`endif

    if (accept) begin
      z         = bus.X ^ k ^ cb_in;
      mode_next = mode_eff;
      if (mode_eff)
        cb_next = (bus.X & k) | (bus.X & cb_in) | (k & cb_in);
      else
        cb_next = (~bus.X & (k | cb_in)) | (k & cb_in);

      case (state_reg)
        BIT0: state_next = BIT1;
        BIT1: state_next = BIT2;
        BIT2: state_next = BIT3;
        default: begin
          state_next      = BIT0;
          digit_done_next = 1'b1;
          if (digit_idx_reg == LAST_IDX) begin
            frame_done_next = 1'b1;
            digit_idx_next  = '0;
          end else begin
            digit_idx_next = digit_idx_reg + 1'b1;
          end
`ifdef SCC_ERR_EN
          if (mode_eff)
            err_next = (digit_val > 4'd9);
          else
            err_next = (digit_val < 4'd3) || (digit_val > 4'd12);
`endif
        end
      endcase

`ifdef SCC_ERR_EN
      case (state_reg)
        BIT0: shadow_next[0] = bus.X;
        BIT1: shadow_next[1] = bus.X;
        BIT2: shadow_next[2] = bus.X;
        default: shadow_next = shadow_reg;
      endcase
`endif
    end
  end

  assign bus.Z          = z;
  assign bus.Digit_done = digit_done_reg;
  assign bus.Frame_done = frame_done_reg;
  assign bus.Err        = err_reg;
  assign bus.Digit_idx  = digit_idx_reg;
endmodule
